risky_regfile_seq: RTL and testbench
====================================

# risky_regfile_seq

Bus sequencer for the 32×32 shared-bus register file. It accepts one register-access request per transaction (up to two source reads plus one destination write), expands it into SELECT/READ/WRITE cycles on the register file's 2-bit control and 32-bit tri-state bus, and returns the read operands through a valid/ready response. It sits between the core's decode/writeback logic and the register file, and is the only driver of that register file's control and bus.

## Interface
Parameters:
- none. Register count (32), index width (5) and data width (32) are fixed.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request (IDLE only)
- req_rs1  in  5  first source index
- req_rs2  in  5  second source index
- req_rd  in  5  destination index
- req_we  in  1  perform the destination write
- req_wdata  in  32  write data
- rsp_valid  out  1  read operands available
- rsp_ready  in  1  consumer takes the response
- rsp_rs1_data  out  32  value of rs1 (pre-write)
- rsp_rs2_data  out  32  value of rs2 (pre-write)
- rf_ctrl  out  2  0 NOP, 1 READ, 2 WRITE, 3 SELECT
- rf_bus  inout  32  shared register-file bus

## Operation
- States: IDLE, SEL1, RD1, SEL2, RD2, SELD, WR, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch rs1/rs2/rd/we/wdata and clear both data outputs to 0.
- Next-state chain after accept, and after each step: go to the first enabled step in the order SEL1 → SEL2 → SELD, else DONE.
  - Read 1 is enabled iff rs1≠0.
  - Read 2 is enabled iff rs2≠0 and rs2≠rs1.
  - Write is enabled iff we=1 and rd≠0.
- rs2==rs1≠0: read 2 is skipped, and rsp_rs2_data takes the rs1 value when RD1 captures.
- Index 0: reads return 0 with no bus cycle. Writes to index 0 are dropped.
- SEL1/SEL2/SELD: rf_ctrl=3, rf_bus driven with {27'b0, index}. Always followed by RD1/RD2/WR respectively.
- RD1/RD2: rf_ctrl=1, rf_bus released (z). At the end of the cycle, sample rf_bus into rsp_rs1_data/rsp_rs2_data.
- WR: rf_ctrl=2, rf_bus driven with the latched wdata.
- Ordering: both reads happen before the write, so read data is always the pre-write value, even when rd equals rs1 or rs2.
- DONE: rsp_valid=1. Data outputs are held stable until rsp_ready. On rsp_valid&&rsp_ready, return to IDLE.
- Bus ownership:
  - The sequencer drives rf_bus only in SEL1, SEL2, SELD and WR. It is z in every other state and during reset.
  - rf_ctrl=0 in IDLE and DONE, so the register file never drives while the sequencer drives.
- No request queueing. req_ready=0 from accept until the cycle after the response handshake.

## Timing
- Reset (async assert, sync-safe deassert), all outputs:
  - state=IDLE
  - req_ready=1
  - rsp_valid=0
  - rsp_rs1_data=0, rsp_rs2_data=0
  - rf_ctrl=0
  - rf_bus=z
- Assertion mid-transaction aborts immediately. A SELECT or WRITE in flight is abandoned, with no completion or response.
- Every enabled step costs 2 cycles. Latency from the accept edge to rsp_valid=1 is 2·(enabled steps)+1 cycles:
  - full transaction (two reads + write): 7 cycles
  - all steps disabled: 1 cycle
- Register-file SELECT takes effect on the edge ending the SEL cycle. READ data is combinational in the following RD cycle. The write commits on the edge ending WR.
- Throughput: one transaction per 2·steps+2 cycles with rsp_ready tied high. Back-to-back accept occurs on the edge after IDLE is re-entered.
- rsp_valid and the data outputs are registered, with no combinational path from req_* or rsp_ready to any output.

## Test plan
- Reset, then a write of rd=5, data 0xDEADBEEF (rs1=rs2=0). Next, read rs1=5, rs2=0 → first response after 3 cycles; second response rs1_data=0xDEADBEEF, rs2_data=0, rf_ctrl trace 3,1.
- Preload x1=0x11, x2=0x22. Request rs1=1, rs2=2, rd=1, we=1, wdata=0x99 → response 7 cycles after accept, rs1_data=0x11, rs2_data=0x22. A follow-up read of x1 returns 0x99.
- Request rs1=3, rs2=3 (x3=0x33) → only one SEL/RD pair on the bus, both outputs 0x33, latency 3.
- Request rs1=0, rs2=0, rd=0, we=1 → no bus activity (rf_ctrl stays 0), rsp_valid 1 cycle after accept, both data 0. A subsequent read of x0 is not issued to the bus.
- Hold rsp_ready=0 for 5 cycles in DONE → rsp_valid and data stay stable, req_ready=0, a new req_valid is ignored. Release → handshake, then accept the next request.
- Assert rst_n=0 during a WR cycle → rf_ctrl=0 and rf_bus=z in the same cycle, no rsp_valid. After release, req_ready=1 and the next transaction completes normally.

Source files
------------

// File: rtl/risky_regfile_seq_if.sv
// Request/response handshake bundle between the core and the register-file
// bus sequencer. The core side is the master, the sequencer is the slave.
interface risky_regfile_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data
  );
endinterface

// File: rtl/risky_regfile_seq.sv
// Bus sequencer for the 32x32 shared-bus register file. Expands one access
// request (two optional reads, one optional write) into SELECT/READ/WRITE
// cycles and returns the pre-write read operands via a valid/ready response.
module risky_regfile_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  risky_regfile_seq_if.slave   bus,
  output logic [1:0]           rf_ctrl,
  inout  wire  [31:0]          rf_bus
);

  typedef enum logic [2:0] {
    IDLE, SEL1, RD1, SEL2, RD2, SELD, WR, DONE
  } state_t;

  localparam logic [1:0] CTRL_NOP    = 2'd0;
  localparam logic [1:0] CTRL_READ   = 2'd1;
  localparam logic [1:0] CTRL_WRITE  = 2'd2;
  localparam logic [1:0] CTRL_SELECT = 2'd3;

  state_t      state, state_next;
  logic [4:0]  rs1, rs2, rd;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rs1_data, rs2_data;

  // In IDLE the step enables come straight from the request being accepted;
  // afterwards they come from the latched copy.
  logic [4:0]  cur_rs1, cur_rs2, cur_rd;
  logic        cur_we;
  logic        en_rd1, en_rd2, en_wr;
  logic        drive_en;
  logic [31:0] drive_val;

  // Select the index/enable source and decode which steps are needed.
  always_comb begin
    cur_rs1 = (state == IDLE) ? bus.req_rs1 : rs1;
    cur_rs2 = (state == IDLE) ? bus.req_rs2 : rs2;
    cur_rd  = (state == IDLE) ? bus.req_rd  : rd;
    cur_we  = (state == IDLE) ? bus.req_we  : we;
    en_rd1  = (cur_rs1 != 5'd0);
    en_rd2  = (cur_rs2 != 5'd0) && (cur_rs2 != cur_rs1);
    en_wr   = cur_we && (cur_rd != 5'd0);
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state walks the enabled steps in order read1, read2, write; the
  // register-file control and bus drive are decoded from the current state.
  always_comb begin
    state_next = state;
    rf_ctrl    = CTRL_NOP;
    drive_en   = 1'b0;
    drive_val  = 32'd0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (en_rd1)      state_next = SEL1;
          else if (en_rd2) state_next = SEL2;
          else if (en_wr)  state_next = SELD;
          else             state_next = DONE;
        end
      end
      SEL1: begin
        rf_ctrl    = CTRL_SELECT;
        drive_en   = 1'b1;
        drive_val  = {27'd0, rs1};
        state_next = RD1;
      end
      RD1: begin
        rf_ctrl = CTRL_READ;
        if (en_rd2)     state_next = SEL2;
        else if (en_wr) state_next = SELD;
        else            state_next = DONE;
      end
      SEL2: begin
        rf_ctrl    = CTRL_SELECT;
        drive_en   = 1'b1;
        drive_val  = {27'd0, rs2};
        state_next = RD2;
      end
      RD2: begin
        rf_ctrl = CTRL_READ;
        if (en_wr) state_next = SELD;
        else       state_next = DONE;
      end
      SELD: begin
        rf_ctrl    = CTRL_SELECT;
        drive_en   = 1'b1;
        drive_val  = {27'd0, rd};
        state_next = WR;
      end
      WR: begin
        rf_ctrl    = CTRL_WRITE;
        drive_en   = 1'b1;
        drive_val  = wdata;
        state_next = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rf_bus = drive_en ? drive_val : 32'bz;

  // Latch the request on accept and capture read data at the end of RD cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1      <= 5'd0;
      rs2      <= 5'd0;
      rd       <= 5'd0;
      we       <= 1'b0;
      wdata    <= 32'd0;
      rs1_data <= 32'd0;
      rs2_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            rs1      <= bus.req_rs1;
            rs2      <= bus.req_rs2;
            rd       <= bus.req_rd;
            we       <= bus.req_we;
            wdata    <= bus.req_wdata;
            rs1_data <= 32'd0;
            rs2_data <= 32'd0;
          end
        end
        RD1: begin
          rs1_data <= rf_bus;
          // Duplicate source: second read is skipped, share the first value.
          if (rs2 == rs1) rs2_data <= rf_bus;
        end
        RD2: rs2_data <= rf_bus;
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.rsp_valid    = (state == DONE);
  assign bus.rsp_rs1_data = rs1_data;
  assign bus.rsp_rs2_data = rs2_data;

endmodule

// File: tb/tb_risky_regfile_seq.sv
// Directed scoreboard bench for risky_regfile_seq with a behavioural model of
// the shared-bus register file attached to rf_ctrl/rf_bus.
module tb_risky_regfile_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rf_ctrl;
  wire  [31:0] rf_bus;

  risky_regfile_seq_if sif();

  risky_regfile_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (sif),
    .rf_ctrl (rf_ctrl),
    .rf_bus  (rf_bus)
  );

  always #5 clk = ~clk;

  // Register-file model: select latches index, read drives combinationally,
  // write commits at the edge ending the WR cycle.
  logic [31:0] mem [32];
  logic [4:0]  sel = 5'd0;
  initial for (int i = 0; i < 32; i++) mem[i] = 32'd0;
  always @(posedge clk) begin
    if (rf_ctrl == 2'd3)      sel <= rf_bus[4:0];
    else if (rf_ctrl == 2'd2) mem[sel] <= rf_bus;
  end
  assign rf_bus = (rf_ctrl == 2'd1) ? mem[sel] : 32'bz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    int          lat;
    int          n;
    logic [11:0] tr;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] act_tr = 12'd0;
  int          act_n = 0;
  logic        seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: record the bus control trace, and on each new response pop the
  // scoreboard and compare data, latency and trace.
  always @(negedge clk) begin
    if (rf_ctrl != 2'd0) begin
      act_tr = {act_tr[9:0], rf_ctrl};
      act_n++;
    end
    if (sif.rsp_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rs1=%h rs2=%h expected no response",
                 sif.rsp_rs1_data, sif.rsp_rs2_data);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("rs1_data", sif.rsp_rs1_data, e.d1);
        chk("rs2_data", sif.rsp_rs2_data, e.d2);
        chk("latency", 32'(cyc - a + 1), 32'(e.lat));
        chk("trace_len", 32'(act_n), 32'(e.n));
        chk("trace", {20'd0, act_tr}, {20'd0, e.tr});
        $display("rsp rs1=%h rs2=%h lat=%0d trace_len=%0d", sif.rsp_rs1_data,
                 sif.rsp_rs2_data, cyc - a + 1, act_n);
      end
      act_tr = 12'd0;
      act_n  = 0;
    end else if (!sif.rsp_valid) begin
      seen = 1'b0;
    end
  end

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi,
                       input logic wei, input logic [31:0] wd, input logic push,
                       input logic [31:0] e1, input logic [31:0] e2, input int lat,
                       input int n, input logic [11:0] tr);
    int k;
    exp_t e;
    @(negedge clk);
    sif.req_rs1   = r1;
    sif.req_rs2   = r2;
    sif.req_rd    = rdi;
    sif.req_we    = wei;
    sif.req_wdata = wd;
    sif.req_valid = 1'b1;
    k = 0;
    while (!sif.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!sif.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end
    if (push) begin
      e.d1 = e1; e.d2 = e2; e.lat = lat; e.n = n; e.tr = tr;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (push) acc_q.push_back(cyc);
    sif.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !sif.req_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    int k;
    sif.req_valid = 1'b0;
    sif.req_rs1   = 5'd0;
    sif.req_rs2   = 5'd0;
    sif.req_rd    = 5'd0;
    sif.req_we    = 1'b0;
    sif.req_wdata = 32'd0;
    sif.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, sif.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("rst_rs1_data", sif.rsp_rs1_data, 32'd0);
    chk("rst_rs2_data", sif.rsp_rs2_data, 32'd0);
    chk("rst_rf_ctrl", {30'd0, rf_ctrl}, 32'd0);
    rst_n = 1'b1;

    // Write x5, then read it back (trace SEL,WR then SEL,RD)
    issue(0, 0, 5, 1, 32'hDEADBEEF, 1, 0, 0, 3, 2, 12'h00E); wait_done();
    issue(5, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 3, 2, 12'h00D); wait_done();

    // Preload x1, x2; full transaction with rd==rs1 returns pre-write values
    issue(0, 0, 1, 1, 32'h11, 1, 0, 0, 3, 2, 12'h00E); wait_done();
    issue(0, 0, 2, 1, 32'h22, 1, 0, 0, 3, 2, 12'h00E); wait_done();
    issue(1, 2, 1, 1, 32'h99, 1, 32'h11, 32'h22, 7, 6, 12'hDDE); wait_done();
    issue(1, 0, 0, 0, 0, 1, 32'h99, 0, 3, 2, 12'h00D); wait_done();

    // Duplicate source: single SEL/RD pair, both outputs equal
    issue(0, 0, 3, 1, 32'h33, 1, 0, 0, 3, 2, 12'h00E); wait_done();
    issue(3, 3, 0, 0, 0, 1, 32'h33, 32'h33, 3, 2, 12'h00D); wait_done();

    // All steps disabled: no bus cycles, latency 1
    issue(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 12'h000); wait_done();
    // rs1 = x0 not on bus, rs2 read alone
    issue(0, 5, 0, 0, 0, 1, 0, 32'hDEADBEEF, 3, 2, 12'h00D); wait_done();
    // rd == rs2: read sees pre-write value; then verify the write landed
    issue(2, 5, 5, 1, 32'h55, 1, 32'h22, 32'hDEADBEEF, 7, 6, 12'hDDE); wait_done();
    issue(5, 3, 0, 0, 0, 1, 32'h55, 32'h33, 5, 4, 12'h0DD); wait_done();

    // Back-pressure: response held, new request ignored
    sif.rsp_ready = 1'b0;
    issue(2, 0, 0, 0, 0, 1, 32'h22, 0, 3, 2, 12'h00D);
    k = 0;
    while (!sif.rsp_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sif.req_rs1   = 5'd1;
      sif.req_rs2   = 5'd0;
      sif.req_we    = 1'b0;
      sif.req_valid = 1'b1;
      chk("hold_rsp_valid", {31'd0, sif.rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, sif.req_ready}, 32'd0);
      chk("hold_rs1_data", sif.rsp_rs1_data, 32'h22);
    end
    @(negedge clk);
    sif.req_valid = 1'b0;
    sif.rsp_ready = 1'b1;
    wait_done();
    issue(3, 0, 0, 0, 0, 1, 32'h33, 0, 3, 2, 12'h00D); wait_done();

    // Reset during WR aborts with no response and no write
    issue(0, 0, 7, 1, 32'h77, 0, 0, 0, 0, 0, 12'h000);
    k = 0;
    while (rf_ctrl != 2'd2 && k < 20) begin @(negedge clk); k++; end
    chk("abort_saw_wr", {30'd0, rf_ctrl}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rf_ctrl", {30'd0, rf_ctrl}, 32'd0);
    chk("abort_rsp_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, sif.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    act_tr = 12'd0;
    act_n  = 0;
    issue(7, 1, 0, 0, 0, 1, 0, 32'h99, 5, 4, 12'h0DD); wait_done();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
